// File: rtl/iir_filter_mc.sv
// Multi-channel first-order recursive filter: y = x + a*s[ch], rounded half-up and saturated.
// Samples are time-multiplexed over one valid/ready stream with a single output register stage.
module iir_filter_mc #(
    parameter int unsigned DW   = 8,
    parameter int unsigned CW   = 8,
    parameter int unsigned FRAC = 6,
    parameter int unsigned NCH  = 4,
    parameter int unsigned CHW  = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clear,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [CHW-1:0]       in_ch,
    input  logic signed [DW-1:0] x,
    input  logic signed [CW-1:0] a,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [CHW-1:0]       out_ch,
    output logic signed [DW-1:0] y,
    output logic                 sat,
    output logic [15:0]          ovf_cnt
);

    localparam int unsigned PW = DW + CW;
    localparam int unsigned TW = PW + 1;
    localparam logic signed [PW-1:0] RndHalf = PW'(2 ** (FRAC - 1));
    localparam logic signed [TW-1:0] YMax    = TW'(2 ** (DW - 1) - 1);
    localparam logic signed [TW-1:0] YMin    = ~YMax;

    logic signed [DW-1:0] s_q [NCH];
    logic signed [DW-1:0] s_cur;
    logic                 hit;
    logic                 accept;

    logic signed [PW-1:0] prod;
    logic signed [PW-1:0] prod_rnd;
    logic signed [PW-1:0] fb;
    logic signed [TW-1:0] sum;
    logic signed [DW-1:0] y_d;
    logic                 sat_d;

    logic                 out_valid_q;
    logic [CHW-1:0]       out_ch_q;
    logic signed [DW-1:0] y_q;
    logic                 sat_q;
    logic [15:0]          ovf_q;

    assign in_ready = !out_valid_q || out_ready;
    assign accept   = in_valid && in_ready;

    // Channel lookup; out-of-range indices leave hit low and select pass-through.
    always_comb begin
        s_cur = '0;
        hit   = 1'b0;
        for (int c = 0; c < int'(NCH); c++) begin
            if (in_ch == CHW'(c)) begin
                hit   = 1'b1;
                s_cur = s_q[c];
            end
        end
        // A same-cycle clear means the accepted sample sees zero history.
        if (clear) begin
            s_cur = '0;
        end
    end

    always_comb begin
        prod     = PW'(a) * PW'(s_cur);
        prod_rnd = prod + RndHalf;
        fb       = prod_rnd >>> FRAC;
        sum      = TW'(x) + TW'(fb);
        y_d      = x;
        sat_d    = 1'b0;
        if (hit) begin
            if (sum > YMax) begin
                y_d   = YMax[DW-1:0];
                sat_d = 1'b1;
            end else if (sum < YMin) begin
                y_d   = YMin[DW-1:0];
                sat_d = 1'b1;
            end else begin
                y_d = sum[DW-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int c = 0; c < int'(NCH); c++) begin
                s_q[c] <= '0;
            end
        end else begin
            if (clear) begin
                for (int c = 0; c < int'(NCH); c++) begin
                    s_q[c] <= '0;
                end
            end
            // Later assignment wins, so an accept overrides the clear on its channel.
            if (accept && hit) begin
                for (int c = 0; c < int'(NCH); c++) begin
                    if (in_ch == CHW'(c)) begin
                        s_q[c] <= y_d;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid_q <= 1'b0;
            out_ch_q    <= '0;
            y_q         <= '0;
            sat_q       <= 1'b0;
        end else if (accept) begin
            out_valid_q <= 1'b1;
            out_ch_q    <= in_ch;
            y_q         <= y_d;
            sat_q       <= sat_d;
        end else if (out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ovf_q <= '0;
        end else if (clear) begin
            ovf_q <= '0;
        end else if (accept && sat_d && (ovf_q != 16'hFFFF)) begin
            ovf_q <= ovf_q + 16'd1;
        end
    end

    assign out_valid = out_valid_q;
    assign out_ch    = out_ch_q;
    assign y         = y_q;
    assign sat       = sat_q;
    assign ovf_cnt   = ovf_q;

endmodule
